// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared constants, entry layout and counter helper functions
//               for the branch target predictor.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_IDX_W  = 4;
  localparam int DEF_CTR_W  = 2;
  localparam int DEF_GHR_W  = 4;
  localparam int MAX_CTR_W  = 4;

  // Entry layout at the default widths; the top stores the same four
  // fields in parallel arrays so that the widths follow its parameters.
  typedef struct packed {
    logic                           valid;
    logic [DEF_ADDR_W-DEF_IDX_W-1:0] tag;
    logic [DEF_ADDR_W-1:0]           target;
    logic [DEF_CTR_W-1:0]            ctr;
  } bp_entry_t;

  // Weakly-taken value: only the MSB set (2^(w-1)).
  function automatic logic [MAX_CTR_W-1:0] weak_taken(input int ctr_w);
    return MAX_CTR_W'(1) << (ctr_w - 1);
  endfunction

  // Weakly-not-taken value: all bits below the MSB set (2^(w-1)-1).
  function automatic logic [MAX_CTR_W-1:0] weak_not_taken(input int ctr_w);
    return weak_taken(ctr_w) - MAX_CTR_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_target_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_predictor_if
// Description : Lookup (fetch) and update (execute) buses of the predictor.
//   lk_pc / lk_hit / lk_taken / lk_target / lk_ghr : fetch-side lookup
//   up_we / up_pc / up_taken / up_target / up_ghr / up_miss : resolved branch
//   slave  : predictor side,  master : pipeline side
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_target_predictor_if import bp_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int GHR_W  = DEF_GHR_W
);
  localparam int HW = (GHR_W > 0) ? GHR_W : 1;

  logic [ADDR_W-1:0] lk_pc;
  logic              lk_hit;
  logic              lk_taken;
  logic [ADDR_W-1:0] lk_target;
  logic [HW-1:0]     lk_ghr;

  logic              up_we;
  logic [ADDR_W-1:0] up_pc;
  logic              up_taken;
  logic [ADDR_W-1:0] up_target;
  logic [HW-1:0]     up_ghr;
  logic              up_miss;

  modport slave (
    input  lk_pc,
    output lk_hit, lk_taken, lk_target, lk_ghr,
    input  up_we, up_pc, up_taken, up_target, up_ghr, up_miss
  );

  modport master (
    output lk_pc,
    input  lk_hit, lk_taken, lk_target, lk_ghr,
    output up_we, up_pc, up_taken, up_target, up_ghr, up_miss
  );
endinterface
`default_nettype wire

// File: rtl/branch_target_predictor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up/down direction counter with parallel load.
//   clk, rst (async, active-low) ; inc, dec, load, load_val ; ctr (state)
//   load has priority over inc, inc over dec.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter import bp_pkg::*; #(
  parameter int CTR_W = DEF_CTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  output logic [CTR_W-1:0] ctr
);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] RST_VAL = CTR_W'(weak_not_taken(CTR_W));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctr <= RST_VAL;
    end else if (load) begin
      ctr <= load_val;
    end else if (inc && (ctr != CTR_MAX)) begin
      ctr <= ctr + CTR_W'(1);
    end else if (dec && (ctr != '0)) begin
      ctr <= ctr - CTR_W'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_predictor
// Description : Direct-mapped branch target buffer with bimodal (GHR_W=0)
//               or gshare (GHR_W>0) direction prediction.
//   clk            : rising-edge clock
//   rst            : asynchronous active-low reset
//   bus (slave)    : combinational lookup + resolved-branch update
//   flush          : synchronous invalidate of all entries and the history
//   stat_updates   : saturating count of accepted updates
//   stat_misses    : saturating count of accepted updates flagged as misses
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_predictor import bp_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int CTR_W  = DEF_CTR_W,
  parameter int GHR_W  = DEF_GHR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  branch_target_predictor_if.slave   bus,
  input  logic                       flush,
  output logic [15:0]                stat_updates,
  output logic [15:0]                stat_misses
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = ADDR_W - IDX_W;
  localparam int HW      = (GHR_W > 0) ? GHR_W : 1;
  // In bimodal mode the history is forced to zero so it never alters an index.
  localparam logic [HW-1:0] GHR_MASK = (GHR_W == 0) ? '0 : '1;

  logic              valid    [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];
  logic [HW-1:0]     ghr;

  function automatic logic [IDX_W-1:0] calc_idx(input logic [IDX_W-1:0] pc_lo,
                                                input logic [HW-1:0]    h);
    return pc_lo ^ IDX_W'(h & GHR_MASK);
  endfunction

  // ---------------- lookup: purely combinational, no update bypass ---------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;

  assign lk_idx        = calc_idx(bus.lk_pc[IDX_W-1:0], ghr);
  assign lk_tag        = bus.lk_pc[ADDR_W-1:IDX_W];
  assign bus.lk_hit    = valid[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign bus.lk_taken  = bus.lk_hit && ctr_q[lk_idx][CTR_W-1];
  assign bus.lk_target = bus.lk_taken ? target_q[lk_idx] : (bus.lk_pc + ADDR_W'(1));
  assign bus.lk_ghr    = ghr;

  // ---------------- update: indexed with the returned snapshot -------------
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             accept;
  logic [CTR_W-1:0] alloc_ctr;

  assign up_idx    = calc_idx(bus.up_pc[IDX_W-1:0], bus.up_ghr);
  assign up_tag    = bus.up_pc[ADDR_W-1:IDX_W];
  assign up_hit    = valid[up_idx] && (tag_q[up_idx] == up_tag);
  assign accept    = bus.up_we && !flush;
  assign alloc_ctr = bus.up_taken ? CTR_W'(weak_taken(CTR_W))
                                  : CTR_W'(weak_not_taken(CTR_W));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]    <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
      ghr          <= '0;
      stat_updates <= '0;
      stat_misses  <= '0;
    end else if (flush) begin
      // Same-cycle update is dropped; targets and statistics are kept.
      for (int i = 0; i < ENTRIES; i++) valid[i] <= 1'b0;
      ghr <= '0;
    end else if (bus.up_we) begin
      if (!up_hit) begin
        valid[up_idx]    <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= bus.up_target;
      end else if (bus.up_taken) begin
        target_q[up_idx] <= bus.up_target;
      end
      ghr <= HW'({ghr, bus.up_taken}) & GHR_MASK;
      if (stat_updates != 16'hFFFF) stat_updates <= stat_updates + 16'd1;
      if (bus.up_miss && (stat_misses != 16'hFFFF)) stat_misses <= stat_misses + 16'd1;
    end
  end

  // ---------------- one direction counter per entry ------------------------
  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    logic sel;
    assign sel = accept && (up_idx == IDX_W'(i));
    sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .clk      (clk),
      .rst      (rst),
      .inc      (sel && up_hit && bus.up_taken),
      .dec      (sel && up_hit && !bus.up_taken),
      .load     (sel && !up_hit),
      .load_val (alloc_ctr),
      .ctr      (ctr_q[i])
    );
  end
endmodule
`default_nettype wire

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning instruction address width.
REQ-002 The block SHALL have parameter IDX_W, default 4, meaning the table holds 2^IDX_W entries.
REQ-003 The block SHALL have parameter CTR_W, default 2, meaning the width of each saturating direction counter (2..4).
REQ-004 The block SHALL have parameter GHR_W, default 4, meaning global history length: 0 selects bimodal mode, 1..IDX_W selects gshare mode.
REQ-005 The block SHALL have port clk, input, width 1: the single clock, rising-edge active.
REQ-006 The block SHALL have port rst, input, width 1: reset, asynchronous and active-low.
REQ-007 The block SHALL have port lk_pc, input, width ADDR_W: the fetch address being looked up.
REQ-008 The block SHALL have port lk_hit, output, width 1: the entry is valid and its tag matches.
REQ-009 The block SHALL have port lk_taken, output, width 1: predicted taken.
REQ-010 The block SHALL have port lk_target, output, width ADDR_W: the predicted next fetch address.
REQ-011 The block SHALL have port lk_ghr, output, width max(GHR_W,1): the history snapshot used for this lookup, carried down the pipeline with the instruction.
REQ-012 The block SHALL have port up_we, input, width 1: a resolved branch is present in execute.
REQ-013 The block SHALL have ports up_pc (ADDR_W), up_taken (1), up_target (ADDR_W) and up_ghr (max(GHR_W,1)), all inputs: the resolved branch address, its outcome, its destination, and its returned snapshot.
REQ-014 The block SHALL have port up_miss, input, width 1: the branch calculator flagged a misprediction.
REQ-015 The block SHALL have port flush, input, width 1: a synchronous invalidate-all request.
REQ-016 The block SHALL have ports stat_updates and stat_misses, outputs, width 16 each: performance counters.

Function
REQ-017 The lookup index SHALL be lk_pc[IDX_W-1:0] XOR the zero-extended GHR in gshare mode, and lk_pc[IDX_W-1:0] in bimodal mode; the tag SHALL be lk_pc[ADDR_W-1:IDX_W].
REQ-018 The lookup SHALL be combinational from registered table state, with zero-cycle latency.
REQ-019 Lookup outputs SHALL be: lk_hit = valid & tag-equal; lk_taken = lk_hit & counter MSB; lk_target = stored target when lk_taken, otherwise lk_pc+1 modulo 2^ADDR_W.
REQ-020 The update index SHALL be computed from up_pc and up_ghr, never from the live GHR.
REQ-021 On up_we with an entry hit, the counter SHALL saturate-increment on up_taken and saturate-decrement otherwise, and the target SHALL be written only when up_taken.
REQ-022 On up_we with an entry miss, the block SHALL allocate (replace) the entry: valid=1, tag written, target=up_target, counter = weakly-taken (2^(CTR_W-1)) if up_taken, else weakly-not-taken (2^(CTR_W-1)-1).
REQ-023 On each up_we, the GHR SHALL become {GHR[GHR_W-2:0], up_taken}; the history is non-speculative.
REQ-024 A lookup and an update to the same index in the same cycle SHALL return the pre-update entry, with no bypass.
REQ-025 On flush, all valid bits and the GHR SHALL clear at the next edge; flush SHALL take priority over a same-cycle up_we, which is dropped; counters, targets and statistics SHALL be unchanged.
REQ-026 stat_updates SHALL increment on each accepted up_we, and stat_misses on each accepted up_we with up_miss; both SHALL saturate at 16'hFFFF.

Reset
REQ-027 While rst=0, asynchronously: all valid bits SHALL be 0, all counters weakly-not-taken, GHR 0, and both statistics 0.
REQ-028 After reset, lk_hit=0, lk_taken=0, lk_target=lk_pc+1, and lk_ghr=0.
REQ-029 Reset asserted mid-update SHALL discard that update; the first update SHALL be accepted at the first rising edge with rst=1.

Structure
REQ-030 Package bp_pkg SHALL hold the default parameter constants, the weakly-taken/not-taken helper functions, and the entry struct (valid, tag, target, ctr).
REQ-031 The direction counter SHALL be one sub-module, sat_counter #(CTR_W), with inc, dec and load ports.

Verification
REQ-032 Reset, lk_pc=10'h005 -> lk_hit=0, lk_taken=0, lk_target=10'h006.
REQ-033 Bimodal mode; up_we with up_pc=10'h012, up_taken=1, up_target=10'h040; then lk_pc=10'h012 -> lk_hit=1, lk_taken=1, lk_target=10'h040.
REQ-034 Bimodal mode; 3 taken updates then 4 not-taken updates to 10'h012 -> counter sequence 2,3,3,2,1,0,0; lk_taken=0 with lk_hit=1.
REQ-035 Aliasing: allocate 10'h012, then update 10'h022 (same index) -> lookup of 10'h012 gives lk_hit=0; lookup of 10'h022 gives lk_hit=1.
REQ-036 Flush and up_we in the same cycle -> all lk_hit=0 afterwards, GHR=0, and stat_updates unchanged.
REQ-037 Gshare mode with GHR_W=4; updates with outcomes 1,1,0,1 -> GHR=4'b1101, and a lookup of lk_pc=10'h003 uses index 4'hE.
